// File: rtl/mem_access_unit_if.sv
// Load/store bus between the CPU memory stage, mem_access_unit and data_ram.
// The slave modport is the unit's own view; master is the CPU/RAM side.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_dout,
        output req_ready, resp_valid, resp_err, resp_rdata, ram_we, ram_addr, ram_din
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_dout,
        input  req_ready, resp_valid, resp_err, resp_rdata, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator: checks each request, performs word accesses on data_ram
// (read-modify-write for sub-word stores) and returns extended load data.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_r, state_next_s;
    logic        we_r, signed_r, err_r;
    logic [1:0]  size_r, lane_r;
    logic [15:0] wdata_r;
    logic [31:0] data_r, data_next_s;
    logic        accept_s, req_err_s;
    logic        req_ready_r, req_ready_s;
    logic        resp_valid_r, resp_valid_s;
    logic        resp_err_r, resp_err_s;
    logic [31:0] resp_rdata_r, resp_rdata_s;
    logic        ram_we_r, ram_we_s;
    logic [31:0] ram_addr_r, ram_addr_s;
    logic [31:0] ram_din_r, ram_din_s;

    function automatic logic check_err_f(input logic [31:0] addr, input logic [1:0] size);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr[0];
            2'b10:   bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad | ((addr >> (ADDR_WIDTH + 2)) != 32'd0);
    endfunction

    function automatic logic [31:0] extract_f(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic sgn);
        logic [31:0] res;
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   res = {{24{sgn & b[7]}}, b};
            2'b01:   res = {{16{sgn & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] merge_f(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [1:0] size, input logic [15:0] wdata);
        logic [31:0] res;
        res = word;
        case (size)
            2'b00:   res[{lane, 3'b000} +: 8] = wdata[7:0];
            2'b01:   res[{lane[1], 4'b0000} +: 16] = wdata;
            default: res = word;
        endcase
        return res;
    endfunction

    assign accept_s  = (state_r == IDLE) && bus.req_valid && req_ready_r;
    assign req_err_s = check_err_f(bus.req_addr, bus.req_size);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decision
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    state_next_s = IDLE;
                end else if (req_err_s) begin
                    state_next_s = RESP;
                end else if (bus.req_we && (bus.req_size == 2'b10)) begin
                    state_next_s = WR;
                end else begin
                    state_next_s = RD;
                end
            end
            RD:      state_next_s = we_r ? WR : RESP;
            WR:      state_next_s = RESP;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Next values of the registered outputs; the response trails the RESP state by one edge
    always_comb begin
        ram_we_s     = (state_next_s == WR);
        req_ready_s  = (state_next_s == IDLE) && (state_r != RESP);
        resp_valid_s = (state_r == RESP);
        resp_err_s   = (state_r == RESP) && err_r;
        resp_rdata_s = ((state_r == RESP) && !err_r && !we_r) ? data_r : 32'd0;
        if (accept_s && !req_err_s) begin
            ram_addr_s = {2'b00, bus.req_addr[31:2]};
        end else begin
            ram_addr_s = ram_addr_r;
        end
        if (accept_s && !req_err_s && bus.req_we && (bus.req_size == 2'b10)) begin
            ram_din_s = bus.req_wdata;
        end else if ((state_r == RD) && we_r) begin
            ram_din_s = merge_f(bus.ram_dout, lane_r, size_r, wdata_r);
        end else begin
            ram_din_s = ram_din_r;
        end
        if ((state_r == RD) && !we_r) begin
            data_next_s = extract_f(bus.ram_dout, lane_r, size_r, signed_r);
        end else begin
            data_next_s = data_r;
        end
    end

    // Request latch and captured load data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r     <= 1'b0;
            signed_r <= 1'b0;
            err_r    <= 1'b0;
            size_r   <= 2'b00;
            lane_r   <= 2'b00;
            wdata_r  <= 16'd0;
            data_r   <= 32'd0;
        end else begin
            if (accept_s) begin
                we_r     <= bus.req_we;
                signed_r <= bus.req_signed;
                err_r    <= req_err_s;
                size_r   <= bus.req_size;
                lane_r   <= bus.req_addr[1:0];
                wdata_r  <= bus.req_wdata[15:0];
            end
            data_r <= data_next_s;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
            ram_we_r     <= 1'b0;
            ram_addr_r   <= 32'd0;
            ram_din_r    <= 32'd0;
        end else begin
            req_ready_r  <= req_ready_s;
            resp_valid_r <= resp_valid_s;
            resp_err_r   <= resp_err_s;
            resp_rdata_r <= resp_rdata_s;
            ram_we_r     <= ram_we_s;
            ram_addr_r   <= ram_addr_s;
            ram_din_r    <= ram_din_s;
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.ram_we     = ram_we_r;
    assign bus.ram_addr   = ram_addr_r;
    assign bus.ram_din    = ram_din_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level reference memory, expectation queue
// filled at issue time and a monitor that checks every RAM write and response.
module tb_mem_access_unit;
    localparam int AW     = 5;
    localparam int NWORDS = 1 << AW;
    localparam int NBYTES = 4 * NWORDS;

    typedef struct {
        logic [31:0] err;
        logic [31:0] rdata;
        int          lat;
        int          nwr;
        logic [31:0] waddr;
        logic [31:0] wdat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if bus();
    mem_access_unit #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0] mem [0:NWORDS-1];
    logic [7:0]  ref_bytes [0:NBYTES-1];
    exp_t        exp_q [$];
    int total = 0, bad = 0, cyc = 0, wr_cnt = 0, n_issued = 0, n_resp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
    endfunction

    function automatic logic model_err(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'b11) || ((sz == 2'b01) && a[0]) ||
               ((sz == 2'b10) && (a[1:0] != 2'b00)) || (a >= 32'(NBYTES));
    endfunction

    // RAM model: registered read and write commit on the falling edge
    initial begin
        bus.ram_dout = 32'd0;
        forever begin
            @(negedge clk);
            bus.ram_dout = mem[bus.ram_addr[AW-1:0]];
            if (bus.ram_we) mem[bus.ram_addr[AW-1:0]] = bus.ram_din;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every write and every response is checked against the queue head
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            wr_cnt = 0;
        end else begin
            if (bus.ram_we) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("ram_we_idle", 32'(bus.ram_we), 32'd0);
                end else begin
                    chk("wr_addr", bus.ram_addr, exp_q[0].waddr);
                    chk("wr_data", bus.ram_din, exp_q[0].wdat);
                end
            end
            if (bus.resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 32'(bus.resp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    n_resp++;
                    chk("resp_err", 32'(bus.resp_err), e.err);
                    chk("resp_rdata", bus.resp_rdata, e.rdata);
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    chk("write_count", 32'(wr_cnt), 32'(e.nwr));
                end
                wr_cnt = 0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_resp_err"}, 32'(bus.resp_err), 32'd0);
        chk({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
        chk({tag, "_ram_we"}, 32'(bus.ram_we), 32'd0);
        chk({tag, "_ram_addr"}, bus.ram_addr, 32'd0);
        chk({tag, "_ram_din"}, bus.ram_din, 32'd0);
    endtask

    // Present a request, wait for acceptance, record the expected outcome
    task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd, input int hold);
        exp_t        e;
        logic        err;
        logic [31:0] v;
        int          nb;
        int          guard;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sgn;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        guard = 0;
        while (!bus.req_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: req_ready still %b after %0d cycles", bus.req_ready, guard);
            bus.req_valid = 1'b0;
            return;
        end
        err = model_err(a, sz);
        nb  = (sz == 2'b11) ? 1 : (1 << sz);
        v   = 32'd0;
        if (!err && we) begin
            for (int i = 0; i < nb; i++) ref_bytes[int'(a) + i] = wd[8*i +: 8];
        end else if (!err) begin
            for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_bytes[int'(a) + i];
            if (sgn && (sz != 2'b10) && v[8*nb-1]) begin
                for (int k = 8*nb; k < 32; k++) v[k] = 1'b1;
            end
        end
        e.err   = {31'd0, err};
        e.rdata = (err || we) ? 32'd0 : v;
        e.lat   = err ? 1 : (!we || sz == 2'b10) ? 2 : 3;
        e.nwr   = (!err && we) ? 1 : 0;
        e.waddr = {2'b00, a[31:2]};
        e.wdat  = err ? 32'd0 : ref_word(int'(a[AW+1:2]));
        e.acc   = cyc + 1;
        exp_q.push_back(e);
        n_issued++;
        repeat (hold) @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d responses still pending", exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [31:0] w, old_w;
        logic [1:0]  sz;
        logic [31:0] a;
        int          guard;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        for (int i = 0; i < NWORDS; i++) begin
            w = (i == 3) ? 32'h8899AABB : $urandom;
            mem[i] = w;
            for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = w[8*b +: 8];
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset");

        // Directed cases around word 3 = 0x8899AABB
        issue(1'b0, 2'b00, 1'b1, 32'h0D, 32'd0, 1);
        issue(1'b0, 2'b01, 1'b0, 32'h0E, 32'd0, 1);
        issue(1'b0, 2'b10, 1'b1, 32'h0C, 32'd0, 1);
        issue(1'b1, 2'b00, 1'b0, 32'h0F, 32'h0000005C, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'd0, 3);
        issue(1'b1, 2'b10, 1'b0, 32'h80, 32'h12345678, 3);
        issue(1'b0, 2'b01, 1'b0, 32'h01, 32'd0, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h06, 32'd0, 1);
        issue(1'b0, 2'b11, 1'b0, 32'h00, 32'd0, 2);
        issue(1'b1, 2'b01, 1'b0, 32'h7E, 32'hCAFEF00D, 1);
        issue(1'b0, 2'b01, 1'b1, 32'h7E, 32'd0, 1);
        drain();
        chk("word3_after_rmw", mem[3], 32'h5C99AABB);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, NBYTES + 15));
            if ($urandom_range(0, 15) == 0) a = $urandom | 32'h00000100;
            if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                  $urandom_range(1, 3));
        end
        drain();

        // Reset while a half store sits in WR, before the falling edge
        old_w = mem[4];
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b01;
        bus.req_signed = 1'b0; bus.req_addr = 32'h12; bus.req_wdata = 32'h0000BEEF;
        guard = 0;
        while (!bus.req_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        guard = 0;
        while (!bus.ram_we && guard < 5) begin
            @(posedge clk);
            #1 guard++;
        end
        chk("wr_state_reached", 32'(bus.ram_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_wr_reset");
        repeat (2) @(negedge clk);
        chk("aborted_word_unchanged", mem[4], old_w);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_abort");
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1);
        drain();

        for (int i = 0; i < NWORDS; i++) chk("ram_contents", mem[i], ref_word(i));
        chk("response_count", 32'(n_resp), 32'(n_issued));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
